// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, state enum and control encodings; MULTICYCLE_CTRL_JAL_EN enables JAL
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BGTZ  = 6'd7;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JALWB  = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_AND   = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REG    = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        pc_src_t    pc_src;
        alu_op_t    alu_op;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_BGTZ,
            OP_ADDI, OP_ANDI, OP_LW, OP_SW: legal = 1'b1;
            default:                         legal = 1'b0;
        endcase
`ifdef MULTICYCLE_CTRL_JAL_EN
        if (op == OP_JAL) legal = 1'b1;
`else
        if (op == OP_JAL) legal = 1'b0;
`endif
        return legal;
    endfunction

endpackage

// File: rtl/mcc_out_dec.sv
// rtl/mcc_out_dec.sv - state-to-control-word decode; all zeros until run is set
module mcc_out_dec
    import mips_ctrl_pkg::*;
(
    input  logic       run,
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       gtz,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        if (run) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_en     = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH;
                    ctrl.illegal   = ~op_legal(opcode);
                end
                S_MEMADR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                S_ALUWB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                S_IEXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    if (opcode == OP_ANDI) ctrl.alu_op = ALU_AND;
                    else                   ctrl.alu_op = ALU_ADD;
                end
                S_IWB: ctrl.reg_write = 1'b1;
                S_BRANCH: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_op    = ALU_SUB;
                    ctrl.pc_src    = PC_ALUOUT;
                    case (opcode)
                        OP_BEQ:  ctrl.pc_en = zero;
                        OP_BNE:  ctrl.pc_en = ~zero;
                        OP_BGTZ: ctrl.pc_en = gtz;
                        default: ctrl.pc_en = 1'b0;
                    endcase
                end
                S_JUMP: begin
                    ctrl.pc_src = PC_JUMP;
                    ctrl.pc_en  = 1'b1;
                end
                // Only reachable when JAL support is built in.
                S_JALWB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.pc_src    = PC_JUMP;
                    ctrl.pc_en     = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS control FSM; MULTICYCLE_CTRL_JAL_EN adds JAL decode
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       gtz,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q, state_nx;
    logic   run;
    ctrl_t  ctrl;

    // run gates every output so reset silences the datapath asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            run     <= 1'b0;
        end else begin
            run <= 1'b1;
            if (run) state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                state_nx = S_EXEC;
                    OP_LW, OP_SW:            state_nx = S_MEMADR;
                    OP_ADDI, OP_ANDI:        state_nx = S_IEXEC;
                    OP_BEQ, OP_BNE, OP_BGTZ: state_nx = S_BRANCH;
                    OP_J:                    state_nx = S_JUMP;
`ifdef MULTICYCLE_CTRL_JAL_EN
                    OP_JAL:                  state_nx = S_JALWB;
`endif
                    default:                 state_nx = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)      state_nx = S_MEMRD;
                else if (opcode == OP_SW) state_nx = S_MEMWR;
                else                      state_nx = S_FETCH;
            end
            S_MEMRD:  if (mem_ready) state_nx = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_nx = S_FETCH;
            S_EXEC:   state_nx = S_ALUWB;
            S_IEXEC:  state_nx = S_IWB;
            default:  state_nx = S_FETCH;
        endcase
    end

    mcc_out_dec u_out_dec (
        .run       (run),
        .state     (state_q),
        .opcode    (opcode),
        .zero      (zero),
        .gtz       (gtz),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_en      = ctrl.pc_en;
    assign ir_write   = ctrl.ir_write;
    assign i_or_d     = ctrl.i_or_d;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign alu_op     = ctrl.alu_op;
    assign illegal    = ctrl.illegal;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed per-cycle checks of multicycle_ctrl; honours MULTICYCLE_CTRL_JAL_EN
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       gtz = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, ir_write, i_or_d, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    // strobe order: pc_en ir_write i_or_d mem_read mem_write reg_write reg_dst mem_to_reg alu_src_a
    localparam logic [8:0] SB_FETCH  = 9'b110100000;
    localparam logic [8:0] SB_FSTALL = 9'b000100000;
    localparam logic [8:0] SB_NONE   = 9'b000000000;
    localparam logic [8:0] SB_A      = 9'b000000001;
    localparam logic [8:0] SB_ALUWB  = 9'b000001100;
    localparam logic [8:0] SB_MEMRD  = 9'b001100000;
    localparam logic [8:0] SB_MEMWB  = 9'b000001010;
    localparam logic [8:0] SB_MEMWR  = 9'b001010000;
    localparam logic [8:0] SB_IWB    = 9'b000001000;
    localparam logic [8:0] SB_BR_T   = 9'b100000001;
    localparam logic [8:0] SB_JUMP   = 9'b100000000;
    localparam logic [8:0] SB_JAL    = 9'b100001000;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .gtz        (gtz),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] obs();
        return {state, pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op, illegal};
    endfunction

    task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] st, input logic [8:0] sb,
                       input logic [1:0] b, input logic [1:0] p, input logic [1:0] a,
                       input logic il);
        #1;
        chk(tag, obs(), {st, sb, b, p, a, il});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string tag, input logic il);
        cyc({tag, "_fetch"}, 4'd0, SB_FETCH, 2'b01, 2'b00, 2'b00, 1'b0);
        cyc({tag, "_dec"},   4'd1, SB_NONE,  2'b11, 2'b00, 2'b00, il);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_now"}, obs(), 20'h0);
        @(posedge clk);
        #1;
        chk({tag, "_hold"}, obs(), 20'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem_ready = 1'b1;
        do_reset("rst0");

        opcode = 6'd0;
        fetch_decode("rt", 1'b0);
        cyc("rt_exec", 4'd6, SB_A,     2'b00, 2'b00, 2'b10, 1'b0);
        cyc("rt_wb",   4'd7, SB_ALUWB, 2'b00, 2'b00, 2'b00, 1'b0);

        opcode = 6'd35;
        fetch_decode("lw", 1'b0);
        cyc("lw_adr", 4'd2, SB_A, 2'b10, 2'b00, 2'b00, 1'b0);
        mem_ready = 1'b0;
        cyc("lw_rd0", 4'd3, SB_MEMRD, 2'b00, 2'b00, 2'b00, 1'b0);
        cyc("lw_rd1", 4'd3, SB_MEMRD, 2'b00, 2'b00, 2'b00, 1'b0);
        mem_ready = 1'b1;
        cyc("lw_rd2", 4'd3, SB_MEMRD, 2'b00, 2'b00, 2'b00, 1'b0);
        cyc("lw_wb",  4'd4, SB_MEMWB, 2'b00, 2'b00, 2'b00, 1'b0);

        opcode = 6'd7; gtz = 1'b1;
        fetch_decode("bgtz1", 1'b0);
        cyc("bgtz1_br", 4'd10, SB_BR_T, 2'b00, 2'b01, 2'b01, 1'b0);

        opcode = 6'd43;
        fetch_decode("sw", 1'b0);
        cyc("sw_adr", 4'd2, SB_A,     2'b10, 2'b00, 2'b00, 1'b0);
        cyc("sw_wr",  4'd5, SB_MEMWR, 2'b00, 2'b00, 2'b00, 1'b0);

        opcode = 6'd5; zero = 1'b1;
        fetch_decode("bne_z", 1'b0);
        cyc("bne_z_br", 4'd10, SB_A, 2'b00, 2'b01, 2'b01, 1'b0);
        zero = 1'b0;
        fetch_decode("bne_nz", 1'b0);
        cyc("bne_nz_br", 4'd10, SB_BR_T, 2'b00, 2'b01, 2'b01, 1'b0);

        opcode = 6'd4; zero = 1'b1;
        fetch_decode("beq", 1'b0);
        cyc("beq_br", 4'd10, SB_BR_T, 2'b00, 2'b01, 2'b01, 1'b0);
        opcode = 6'd7; gtz = 1'b0;
        fetch_decode("bgtz0", 1'b0);
        cyc("bgtz0_br", 4'd10, SB_A, 2'b00, 2'b01, 2'b01, 1'b0);

        opcode = 6'd8;
        fetch_decode("addi", 1'b0);
        cyc("addi_ex", 4'd8, SB_A,   2'b10, 2'b00, 2'b00, 1'b0);
        cyc("addi_wb", 4'd9, SB_IWB, 2'b00, 2'b00, 2'b00, 1'b0);
        opcode = 6'd12;
        fetch_decode("andi", 1'b0);
        cyc("andi_ex", 4'd8, SB_A,   2'b10, 2'b00, 2'b11, 1'b0);
        cyc("andi_wb", 4'd9, SB_IWB, 2'b00, 2'b00, 2'b00, 1'b0);

        opcode = 6'd2;
        fetch_decode("j", 1'b0);
        cyc("j_jump", 4'd11, SB_JUMP, 2'b00, 2'b10, 2'b00, 1'b0);

        opcode = 6'd3;
`ifdef MULTICYCLE_CTRL_JAL_EN
        fetch_decode("jal", 1'b0);
        cyc("jal_wb", 4'd12, SB_JAL, 2'b00, 2'b10, 2'b00, 1'b0);
`else
        fetch_decode("jal_ill", 1'b1);
`endif

        opcode = 6'd63;
        fetch_decode("ill63", 1'b1);
        mem_ready = 1'b0;
        cyc("fetch_stall", 4'd0, SB_FSTALL, 2'b01, 2'b00, 2'b00, 1'b0);
        mem_ready = 1'b1;

        opcode = 6'd43;
        fetch_decode("sw2", 1'b0);
        cyc("sw2_adr", 4'd2, SB_A, 2'b10, 2'b00, 2'b00, 1'b0);
        mem_ready = 1'b0;
        cyc("sw2_wr0", 4'd5, SB_MEMWR, 2'b00, 2'b00, 2'b00, 1'b0);
        cyc("sw2_wr1", 4'd5, SB_MEMWR, 2'b00, 2'b00, 2'b00, 1'b0);
        do_reset("rst_mid");

        mem_ready = 1'b1;
        opcode = 6'd0;
        fetch_decode("rt2", 1'b0);
        cyc("rt2_exec", 4'd6, SB_A,     2'b00, 2'b00, 2'b10, 1'b0);
        cyc("rt2_wb",   4'd7, SB_ALUWB, 2'b00, 2'b00, 2'b00, 1'b0);
        cyc("rt2_back", 4'd0, SB_FETCH, 2'b01, 2'b00, 2'b00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
